// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display scan controller family.
package disp_pkg;

    localparam int N_DIGITS = 4;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [N_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Select nibble i (digit i) out of the packed hex word.
    function automatic logic [3:0] nibble_at(input logic [4*N_DIGITS-1:0] value,
                                             input logic [IDX_W-1:0] i);
        return value[{i, 2'b00} +: 4];
    endfunction

    // Active-low anode pattern lighting only digit i.
    function automatic logic [N_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] i);
        return ~(4'b0001 << i);
    endfunction

endpackage

// File: rtl/hex_lz_mask.sv
// Leading-zero mask for a packed hex word: bit i is set when digit i and every
// digit above it are zero. Digit 0 is never masked so a zero value still shows "0".
module hex_lz_mask #(
    parameter int N_DIG = 4
) (
    input  logic [4*N_DIG-1:0] value,
    output logic [N_DIG-1:0]   mask
);

    logic run_zero;

    // Walk from the most significant digit down, tracking "all zero so far".
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred,
        // and blocking assignments are used so run_zero updates within the loop.
        mask     = '0;
        run_zero = 1'b1;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            run_zero = run_zero & (value[i*4 +: 4] == 4'h0);
            mask[i]  = run_zero;
        end
        mask[0] = 1'b0;
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller feeding an MC14495 decoder and four active-low digit anodes.
// Each digit slot is an all-off gap followed by a lit dwell; inputs are
// snapshotted when digit 0 is entered so a frame never tears.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] hex_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  le_in,
    input  logic        lz_sup,
    output logic [3:0]  AN,
    output logic [3:0]  Hex,
    output logic        point,
    output logic        LE,
    output logic        frame_done
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    scan_state_e        state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;

    logic [15:0]        snap_hex;
    logic [3:0]         snap_pt;
    logic [3:0]         snap_le;
    logic [3:0]         snap_mask;

    logic [3:0]         raw_mask;
    logic [3:0]         live_mask;
    logic [3:0]         entry_hex;
    logic               entry_pt;
    logic               entry_le;

    // Mask is evaluated on the live inputs and captured with the snapshot.
    hex_lz_mask #(
        .N_DIG (N_DIGITS)
    ) u_lz_mask (
        .value (hex_in),
        .mask  (raw_mask)
    );

    // Suppression disabled means no digit is ever masked.
    always_comb begin
        live_mask = lz_sup ? raw_mask : '0;
    end

    // Values driven when entering SHOW(idx); digit 0 bypasses the snapshot
    // because the snapshot is being taken on that very edge.
    always_comb begin
        entry_hex = nibble_at(snap_hex, idx);
        entry_pt  = snap_pt[idx];
        entry_le  = snap_le[idx] | snap_mask[idx];
        if (idx == '0) begin
            entry_hex = hex_in[3:0];
            entry_pt  = point_in[0];
            entry_le  = le_in[0] | live_mask[0];
        end
    end

    // Scan FSM with registered decoder/anode outputs and per-frame snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state      <= ST_BLANK;
            idx        <= '0;
            cnt        <= '0;
            AN         <= AN_OFF;
            Hex        <= 4'h0;
            point      <= 1'b0;
            LE         <= 1'b1;
            frame_done <= 1'b0;
            // NOTE: the snapshot registers are reset too, so a frame shown right
            // after reset never depends on uninitialised storage.
            snap_hex   <= '0;
            snap_pt    <= '0;
            snap_le    <= '0;
            snap_mask  <= '0;
        end else if (!en) begin
            state      <= ST_BLANK;
            idx        <= '0;
            cnt        <= '0;
            AN         <= AN_OFF;
            LE         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= ST_SHOW;
                        cnt   <= '0;
                        AN    <= anode_for(idx);
                        Hex   <= entry_hex;
                        point <= entry_pt;
                        LE    <= entry_le;
                        if (idx == '0) begin
                            snap_hex  <= hex_in;
                            snap_pt   <= point_in;
                            snap_le   <= le_in;
                            snap_mask <= live_mask;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                        idx   <= idx + 1'b1;
                        AN    <= AN_OFF;
                        LE    <= 1'b1;
                        if (idx == IDX_LAST) begin
                            frame_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a frame-position reference model pushes
// the expected output bundle after every clock edge; a monitor pops and compares.
module tb_disp_scan_ctrl;

    localparam int B      = 2;
    localparam int D      = 4;
    localparam int SLOT   = B + D;
    localparam int PERIOD = 4 * SLOT;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic [15:0] hex_in = 16'h1A3F;
    logic [3:0]  point_in = 4'b0101;
    logic [3:0]  le_in = 4'b0000;
    logic        lz_sup = 1'b0;
    logic [3:0]  AN;
    logic [3:0]  Hex;
    logic        point;
    logic        LE;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] hex;
        logic       pt;
        logic       le;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;

    // Reference model state
    int          k = 0;
    logic [15:0] m_hex = '0;
    logic [3:0]  m_pt = '0;
    logic [3:0]  m_le = '0;
    logic        m_lz = 1'b0;
    obs_t        e = '{an: 4'hF, hex: 4'h0, pt: 1'b0, le: 1'b1, fd: 1'b0};

    disp_scan_ctrl #(
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hex_in     (hex_in),
        .point_in   (point_in),
        .le_in      (le_in),
        .lz_sup     (lz_sup),
        .AN         (AN),
        .Hex        (Hex),
        .point      (point),
        .LE         (LE),
        .frame_done (frame_done)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Digit d is dark by leading-zero suppression when everything from d upward is zero.
    function automatic logic lz_dark(input logic [15:0] v, input logic lz, input int d);
        return lz && (d != 0) && ((v >> (4 * d)) == 16'h0);
    endfunction

    // Model: outputs follow purely from the edge count k since the scan (re)started.
    initial forever begin
        int p, slot, ph;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            k = 0;
            m_hex = '0; m_pt = '0; m_le = '0; m_lz = 1'b0;
            e = '{an: 4'hF, hex: 4'h0, pt: 1'b0, le: 1'b1, fd: 1'b0};
            exp_q.delete();
        end else begin
            if (!en) begin
                k = 0;
                e.an = 4'hF; e.le = 1'b1; e.fd = 1'b0;
            end else begin
                k++;
                p    = k % PERIOD;
                slot = p / SLOT;
                ph   = p % SLOT;
                if (p == B) begin
                    m_hex = hex_in; m_pt = point_in; m_le = le_in; m_lz = lz_sup;
                end
                e.fd = (p == 0);
                if (ph < B) begin
                    e.an = 4'hF;
                    e.le = 1'b1;
                end else begin
                    e.an  = 4'(15 - (1 << slot));
                    e.hex = 4'(m_hex >> (4 * slot));
                    e.pt  = m_pt[slot];
                    e.le  = m_le[slot] | lz_dark(m_hex, m_lz, slot);
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare the DUT against the oldest expectation, mid-cycle.
    initial forever begin
        obs_t want;
        @(negedge clk);
        if (rst_n && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("scan_outputs", {21'h0, AN, Hex, point, LE, frame_done}, {21'h0, want});
        end
    end

    task automatic reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_AN"}, {28'h0, AN}, 32'hF);
        check({tag, "_Hex"}, {28'h0, Hex}, 32'h0);
        check({tag, "_point"}, {31'h0, point}, 32'h0);
        check({tag, "_LE"}, {31'h0, LE}, 32'h1);
        check({tag, "_frame_done"}, {31'h0, frame_done}, 32'h0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the negedge where the model is at frame position p.
    task automatic wait_pos(input int p);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            @(negedge clk);
            if (en && rst_n && (k % PERIOD) == p) found = 1'b1;
        end
        check("wait_pos", {31'h0, found}, 32'h1);
    endtask

    initial begin
        // Reset asserted with the clock stopped must act immediately.
        #5;
        reset_check("rst_noclk");
        #4;
        clk_run = 1'b1;
        cycles(2);
        rst_n = 1'b1;

        // Normal frames, then a mid-frame input change that must not tear.
        cycles(2 * PERIOD);
        wait_pos(2 * SLOT - 3);
        hex_in = 16'h0000;
        cycles(2 * PERIOD);

        // Leading-zero suppression.
        hex_in = 16'h0050; lz_sup = 1'b1;
        cycles(2 * PERIOD);
        hex_in = 16'h0000;
        cycles(2 * PERIOD);

        // Enable drop in the second cycle of SHOW(2), then recovery.
        hex_in = 16'hC0DE; lz_sup = 1'b0;
        wait_pos(2 * SLOT + B + 1);
        en = 1'b0;
        cycles(5);
        hex_in = 16'h4B7E; point_in = 4'b1010;
        en = 1'b1;
        cycles(PERIOD + 2);

        // Enable drop exactly on the expiry edge of SHOW(3): no frame_done.
        wait_pos(PERIOD - 1);
        en = 1'b0;
        cycles(3);
        en = 1'b1;
        cycles(PERIOD);

        // Per-digit blank request.
        le_in = 4'b1000; hex_in = 16'h8888; point_in = 4'b0000;
        cycles(2 * PERIOD);

        // Reset in the middle of a frame.
        wait_pos(SLOT + B + 2);
        @(posedge clk);
        #2;
        reset_check("rst_midframe");
        cycles(2);
        rst_n = 1'b1;
        le_in = 4'b0000;
        cycles(PERIOD + 4);

        // Randomized input churn including enable toggles.
        for (int it = 0; it < 40; it++) begin
            cycles($urandom_range(1, 20));
            case ($urandom_range(0, 5))
                0: hex_in = 16'($urandom);
                1: hex_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
                2: point_in = 4'($urandom);
                3: le_in = 4'($urandom);
                4: lz_sup = ~lz_sup;
                default: en = ~en;
            endcase
        end
        en = 1'b1;
        cycles(2 * PERIOD);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
